// File: rtl/tmr_voter_monitor.sv
// ---------------------------------------------------------------------------
// tmr_voter_monitor
//
// Registered majority voter for a triplicated (TMR) bus. It also works out
// which replica disagreed, keeps sticky and failed flags per replica, counts
// mismatch cycles in a saturating counter, and detects persistent faults.
// When one replica fails, the block drops it and runs from the remaining pair
// (DEGRADED). When a second failure appears, the block reports FATAL.
//
// Parameters
//   WIDTH     data width per replica
//   REG_OUT   1: out/tmrErr registered (1-cycle latency), 0: combinational
//   CNT_WIDTH width of the saturating mismatch counter errCnt
//   PERSIST   consecutive deviating cycles (>=1) that declare a failure
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   inA, inB, inC      the three replicas
//   clr                synchronous clear of counters/flags, state -> TRIPLE
//   out, tmrErr        voted data and mismatch flag for the same sample
//   errA/B/C           sticky: replica deviated from the majority (TRIPLE)
//   failA/B/C          replica declared failed
//   fatal              two or more failures (state FATAL)
//   errCnt             saturating count of mismatch cycles
//   dbgState           current voter state (TRIPLE/DEGRADED/FATAL)
// ---------------------------------------------------------------------------
module tmr_voter_monitor #(
    parameter int WIDTH     = 8,
    parameter int REG_OUT   = 1,
    parameter int CNT_WIDTH = 16,
    parameter int PERSIST   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     inA,
    input  logic [WIDTH-1:0]     inB,
    input  logic [WIDTH-1:0]     inC,
    input  logic                 clr,
    output logic [WIDTH-1:0]     out,
    output logic                 tmrErr,
    output logic                 errA,
    output logic                 errB,
    output logic                 errC,
    output logic                 failA,
    output logic                 failB,
    output logic                 failC,
    output logic                 fatal,
    output logic [CNT_WIDTH-1:0] errCnt,
    output logic [1:0]           dbgState
);

    localparam int PW = (PERSIST < 1) ? 1 : $clog2(PERSIST + 1);
    localparam logic [PW-1:0]        P_MAX   = PW'(PERSIST);
    localparam logic [PW-1:0]        P_LAST  = PW'(PERSIST - 1);
    localparam logic [PW-1:0]        P_ONE   = PW'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_TRIPLE   = 2'd0,
        ST_DEGRADED = 2'd1,
        ST_FATAL    = 2'd2
    } state_t;

    // Registered state
    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       out_q;
    logic                   tmr_err_q;
    logic [2:0]             err_q, err_d;     // index 0=A, 1=B, 2=C
    logic [2:0]             fail_q, fail_d;
    logic                   fatal_q, fatal_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]          run_q [3];
    logic [PW-1:0]          run_d [3];
    logic [PW-1:0]          pair_q, pair_d;   // DEGRADED disagreement run

    // Combinational voting terms
    logic [WIDTH-1:0]       maj;
    logic [2:0]             dev;
    logic [2:0]             hit;
    logic [WIDTH-1:0]       good1, good2;
    logic [WIDTH-1:0]       sel;
    logic                   mis;

    assign maj    = (inA & inB) | (inA & inC) | (inB & inC);
    assign dev[0] = |(inA ^ maj);
    assign dev[1] = |(inB ^ maj);
    assign dev[2] = |(inC ^ maj);

    // Surviving pair in DEGRADED, lower letter first so that good1 is the
    // replica forwarded to out.
    always_comb begin
        good1 = inA;
        good2 = inB;
        if (fail_q[0]) begin
            good1 = inB;
            good2 = inC;
        end else if (fail_q[1]) begin
            good2 = inC;
        end
    end

    always_comb begin
        sel = maj;
        mis = 1'b0;
        case (state_q)
            ST_TRIPLE: begin
                sel = maj;
                mis = |dev;
            end
            ST_DEGRADED: begin
                sel = good1;
                mis = |(good1 ^ good2);
            end
            ST_FATAL: begin
                sel = maj;
                mis = 1'b1;
            end
            default: begin
                sel = maj;
                mis = 1'b1;
            end
        endcase
    end

    // Next-state logic for every status register
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        fail_d  = fail_q;
        pair_d  = pair_q;
        hit     = 3'b000;
        for (int i = 0; i < 3; i++) begin
            run_d[i] = run_q[i];
        end

        if (mis && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end

        case (state_q)
            ST_TRIPLE: begin
                err_d = err_q | dev;
                for (int i = 0; i < 3; i++) begin
                    // A replica fails on the edge its run reaches PERSIST.
                    hit[i] = dev[i] && (run_q[i] == P_LAST);
                    if (!dev[i]) begin
                        run_d[i] = '0;
                    end else if (run_q[i] != P_MAX) begin
                        run_d[i] = run_q[i] + P_ONE;
                    end
                end
                fail_d = fail_q | hit;
                if (hit != 3'b000) begin
                    if ($onehot(hit)) begin
                        state_d = ST_DEGRADED;
                        pair_d  = '0;
                    end else begin
                        state_d = ST_FATAL;
                    end
                end
            end
            ST_DEGRADED: begin
                // Persistent disagreement in the surviving pair is a second
                // failure; which one is wrong is unknowable, so only FATAL.
                if (mis) begin
                    pair_d = pair_q + P_ONE;
                    if (pair_q == P_LAST) begin
                        state_d = ST_FATAL;
                    end
                end else begin
                    pair_d = '0;
                end
            end
            ST_FATAL: begin
                state_d = ST_FATAL;
            end
            default: begin
                state_d = ST_TRIPLE;
            end
        endcase

        // clr overrides the fault updates of this cycle.
        if (clr) begin
            state_d = ST_TRIPLE;
            err_d   = '0;
            fail_d  = '0;
            cnt_d   = '0;
            pair_d  = '0;
            for (int i = 0; i < 3; i++) begin
                run_d[i] = '0;
            end
        end

        fatal_d = (state_d == ST_FATAL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_TRIPLE;
            out_q     <= '0;
            tmr_err_q <= 1'b0;
            err_q     <= '0;
            fail_q    <= '0;
            fatal_q   <= 1'b0;
            cnt_q     <= '0;
            pair_q    <= '0;
            for (int i = 0; i < 3; i++) begin
                run_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            out_q     <= sel;
            tmr_err_q <= mis;
            err_q     <= err_d;
            fail_q    <= fail_d;
            fatal_q   <= fatal_d;
            cnt_q     <= cnt_d;
            pair_q    <= pair_d;
            for (int i = 0; i < 3; i++) begin
                run_q[i] <= run_d[i];
            end
        end
    end

    assign out      = (REG_OUT != 0) ? out_q : sel;
    assign tmrErr   = (REG_OUT != 0) ? tmr_err_q : mis;
    assign errA     = err_q[0];
    assign errB     = err_q[1];
    assign errC     = err_q[2];
    assign failA    = fail_q[0];
    assign failB    = fail_q[1];
    assign failC    = fail_q[2];
    assign fatal    = fatal_q;
    assign errCnt   = cnt_q;
    assign dbgState = state_q;

endmodule
